// File: rtl/mips_multicycle_ctrl_if.sv
// Bundle between the multicycle MIPS controller and its datapath.
// Datapath -> controller: op, funct (IR fields), zero (ALU flag).
// Controller -> datapath: PC/memory/IR/regfile enables, mux selects,
// alucontrol, debug state and illegal-opcode pulse.
interface mips_multicycle_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       alusrca;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic       illegal;

   // Controller side
   modport master (
      input  op, funct, zero,
      output pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
             regdst, alusrcb, pcsrc, alucontrol, state, illegal
   );

   // Datapath side
   modport slave (
      output op, funct, zero,
      input  pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg,
             regdst, alusrcb, pcsrc, alucontrol, state, illegal
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM and ALU decoder for the multicycle MIPS core.
// Ports: clk, reset (synchronous, active-high), bus (master modport of
// mips_multicycle_ctrl_if carrying IR fields in and datapath controls out).
// Controls are Moore decodes of the state register; pcen also depends on
// zero and alucontrol on funct. Write enables are gated off while reset=1.
module mips_multicycle_ctrl (
   input  logic                          clk,
   input  logic                          reset,
   mips_multicycle_ctrl_if.master        bus
);

   localparam int unsigned STATE_W = 4;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [STATE_W-1:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTYPEEX = 4'd6,
      RTYPEWB = 4'd7,
      BEQEX   = 4'd8,
      ADDIEX  = 4'd9,
      ADDIWB  = 4'd10,
      JEX     = 4'd11
   } state_e;

   state_e     state_q, state_d;

   logic       pcwrite_c, branch_c;
   logic       memwrite_c, irwrite_c, regwrite_c, illegal_c;
   logic       alusrca_c, iord_c, memtoreg_c, regdst_c;
   logic [1:0] alusrcb_c, pcsrc_c, aluop_c;
   logic [2:0] alucontrol_c;

   // State register
   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // Next-state and Moore control decode
   always_comb begin
      state_d    = FETCH;
      pcwrite_c  = 1'b0;
      branch_c   = 1'b0;
      memwrite_c = 1'b0;
      irwrite_c  = 1'b0;
      regwrite_c = 1'b0;
      illegal_c  = 1'b0;
      alusrca_c  = 1'b0;
      iord_c     = 1'b0;
      memtoreg_c = 1'b0;
      regdst_c   = 1'b0;
      alusrcb_c  = 2'b00;
      pcsrc_c    = 2'b00;
      aluop_c    = 2'b00;

      case (state_q)
         FETCH: begin
            irwrite_c = 1'b1;
            pcwrite_c = 1'b1;
            alusrcb_c = 2'b01;
            state_d   = DECODE;
         end
         DECODE: begin
            alusrcb_c = 2'b11;
            case (bus.op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = RTYPEEX;
               OP_BEQ:       state_d = BEQEX;
               OP_ADDI:      state_d = ADDIEX;
               OP_J:         state_d = JEX;
               default: begin
                  state_d   = FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'b10;
            // Only lw/sw reach here, so anything but sw is a load
            state_d   = (bus.op == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            iord_c  = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            memtoreg_c = 1'b1;
            regwrite_c = 1'b1;
         end
         MEMWR: begin
            iord_c     = 1'b1;
            memwrite_c = 1'b1;
         end
         RTYPEEX: begin
            alusrca_c = 1'b1;
            aluop_c   = 2'b10;
            state_d   = RTYPEWB;
         end
         RTYPEWB: begin
            regdst_c   = 1'b1;
            regwrite_c = 1'b1;
         end
         BEQEX: begin
            alusrca_c = 1'b1;
            aluop_c   = 2'b01;
            pcsrc_c   = 2'b01;
            branch_c  = 1'b1;
         end
         ADDIEX: begin
            alusrca_c = 1'b1;
            alusrcb_c = 2'b10;
            state_d   = ADDIWB;
         end
         ADDIWB: begin
            regwrite_c = 1'b1;
         end
         JEX: begin
            pcsrc_c   = 2'b10;
            pcwrite_c = 1'b1;
         end
         default: state_d = FETCH;
      endcase
   end

   // ALU decoder
   always_comb begin
      alucontrol_c = 3'b010;
      case (aluop_c)
         2'b00: alucontrol_c = 3'b010;
         2'b01: alucontrol_c = 3'b110;
         2'b10: begin
            case (bus.funct)
               6'b100000: alucontrol_c = 3'b010;
               6'b100010: alucontrol_c = 3'b110;
               6'b100100: alucontrol_c = 3'b000;
               6'b100101: alucontrol_c = 3'b001;
               6'b101010: alucontrol_c = 3'b111;
               default:   alucontrol_c = 3'b010;
            endcase
         end
         default: alucontrol_c = 3'b010;
      endcase
   end

   // Write enables and the illegal pulse are suppressed during reset
   assign bus.pcen       = ~reset & (pcwrite_c | (branch_c & bus.zero));
   assign bus.memwrite   = ~reset & memwrite_c;
   assign bus.irwrite    = ~reset & irwrite_c;
   assign bus.regwrite   = ~reset & regwrite_c;
   assign bus.illegal    = ~reset & illegal_c;
   assign bus.alusrca    = alusrca_c;
   assign bus.iord       = iord_c;
   assign bus.memtoreg   = memtoreg_c;
   assign bus.regdst     = regdst_c;
   assign bus.alusrcb    = alusrcb_c;
   assign bus.pcsrc      = pcsrc_c;
   assign bus.alucontrol = alucontrol_c;
   assign bus.state      = STATE_W'(state_q);

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Main control FSM plus ALU decoder for the multicycle MIPS core.
- Sequences a shared-memory datapath (single instruction/data memory, IR, A/B/ALUOut registers) one instruction at a time over 3-5 cycles.
- Sits inside the processor between the instruction register fields and the datapath mux selects and write enables.
- Also reports its current state and flags unsupported opcodes.

Parameters:
- None. Encodings below are fixed.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- pcen  out  1  PC register enable
- memwrite  out  1  memory write enable
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write enable
- alusrca  out  1  0=PC, 1=A
- iord  out  1  memory address: 0=PC, 1=ALUOut
- memtoreg  out  1  writeback: 0=ALUOut, 1=Data
- regdst  out  1  dest reg: 0=rt, 1=rd
- alusrcb  out  2  00=B, 01=4, 10=SignImm, 11=SignImm<<2
- pcsrc  out  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  out  3  ALU op select
- state  out  4  current FSM state, for debug and verification
- illegal  out  1  one-cycle pulse on unsupported opcode

Behaviour:
- State encoding (4 bits):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11
  - Codes 12-15 are unreachable; if ever entered, next state is FETCH.
- Reset:
  - When reset=1 at a rising edge, state becomes FETCH.
  - While reset=1, pcen, memwrite, irwrite, regwrite and illegal are forced to 0 regardless of state.
  - Reset mid-instruction abandons the instruction with no further writes.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> RTYPEEX
    - 000100 (beq) -> BEQEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - any other op -> FETCH, with illegal=1 for that DECODE cycle
  - MEMADR -> MEMRD if lw, MEMWR if sw.
  - MEMRD -> MEMWB.
  - RTYPEEX -> RTYPEWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Outputs are Moore (combinational from state), except pcen and alucontrol (funct). Any output not listed for a state is 0.
  - FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
  - DECODE: alusrcb=11, aluop=00.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWB: regdst=1, regwrite=1.
  - BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWB: regwrite=1.
  - JEX: pcsrc=10, pcwrite=1.
- pcen = pcwrite | (branch & zero). pcwrite and branch are internal only.
- ALU decoder:
  - aluop 00 -> alucontrol 010 (add); aluop 01 -> 110 (sub).
  - aluop 10, by funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - any other funct -> 010
- Instruction latency in cycles, FETCH inclusive:
  - lw 5; sw, R-type, addi 4; beq, j 3; illegal 2.
- No output is X in any state, including unreachable codes.

Test Plan:
- Reset held 2 cycles, then released with op=100011 -> state 0,1,2,3,4,0. memwrite never 1. regwrite=1 only in state 4, with memtoreg=1, regdst=0.
- op=101011 -> states 0,1,2,5,0. In state 5: memwrite=1, iord=1. regwrite=0 throughout.
- op=000000, funct=100010 -> state 6 gives alucontrol=110, alusrca=1. State 7 gives regwrite=1, regdst=1. Repeat with funct=101010 -> alucontrol=111, and funct=111111 -> alucontrol=010.
- op=000100 with zero=1 in BEQEX -> pcen=1, pcsrc=01. Same with zero=0 -> pcen=0. Both return to FETCH after 3 cycles.
- op=000010 -> JEX with pcen=1, pcsrc=10. op=111111 -> illegal=1 for one cycle in DECODE, then FETCH with no write enables asserted.
- Assert reset during MEMWR -> next state is FETCH. memwrite=0 while reset is high. Fetch restarts normally on release.
